// File: rtl/bpm_timing_pkg.sv
// Shared types and helpers for the BPM integrator timing stage.
package bpm_timing_pkg;

    localparam int unsigned CNT_W_DEFAULT = 7;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StStrobe,
        StGap,
        StCond
    } state_e;

    // First non-empty phase, given which of delay/length/gap are non-zero.
    function automatic state_e entry_state(input logic s_nz, input logic l_nz,
                                           input logic d_nz);
        if (s_nz) begin
            return StDelay;
        end else if (l_nz) begin
            return StStrobe;
        end else if (d_nz) begin
            return StGap;
        end
        return StCond;
    endfunction

endpackage

// File: rtl/strb_down_counter.sv
// Loadable down-counter; tc marks the last cycle of a loaded count of N (N cycles total).
module strb_down_counter #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - One;
        end
    end

    assign tc = (cnt_q == One);

endmodule

// File: rtl/bunch_strobe_gen.sv
// Trigger-driven strobe window followed by a single dac_cond pulse.
// Define STRB_DECIM_EN to add strb_step decimation of the strobe window.
module bunch_strobe_gen
    import bpm_timing_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [CNT_W-1:0] strb_start,
    input  logic [CNT_W-1:0] strb_len,
    input  logic [CNT_W-1:0] dac_delay,
`ifdef STRB_DECIM_EN
    input  logic [CNT_W-1:0] strb_step,
`endif
    output logic             bunch_strb,
    output logic             dac_cond,
    output logic             busy,
    output logic [CNT_W-1:0] strb_cnt
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, gap_q;
    logic [CNT_W-1:0] len_eff, gap_eff, load_val;
    logic             accept, load, tc, strb_hit;

    assign accept  = (state_q == StIdle) && trig;
    // Settings are taken straight from the inputs on the accepting edge.
    assign len_eff = (state_q == StIdle) ? strb_len : len_q;
    assign gap_eff = (state_q == StIdle) ? dac_delay : gap_q;
    assign busy    = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (trig) state_d = entry_state(strb_start != '0, strb_len != '0,
                                                      dac_delay != '0);
            StDelay:  if (tc) state_d = entry_state(1'b0, len_q != '0, gap_q != '0);
            StStrobe: if (tc) state_d = entry_state(1'b0, 1'b0, gap_q != '0);
            StGap:    if (tc) state_d = StCond;
            StCond:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        load_val = '0;
        unique case (state_d)
            StDelay:  load_val = strb_start;
            StStrobe: load_val = len_eff;
            StGap:    load_val = gap_eff;
            default:  load_val = '0;
        endcase
    end

    assign load = (state_d != state_q);

    strb_down_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

`ifdef STRB_DECIM_EN
    logic [CNT_W-1:0] step_q, step_n, phase_q, phase_d;

    // phase tracks the next window cycle index modulo max(step, 1).
    assign step_n   = (step_q == '0) ? CntOne : step_q;
    assign phase_d  = (state_q != StStrobe) ? '0 :
                      (phase_q >= step_n - CntOne) ? '0 : phase_q + CntOne;
    assign strb_hit = (phase_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q  <= '0;
            phase_q <= '0;
        end else begin
            if (accept) begin
                step_q <= strb_step;
            end
            phase_q <= phase_d;
        end
    end
`else
    assign strb_hit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bunch_strb <= 1'b0;
            dac_cond   <= 1'b0;
            len_q      <= '0;
            gap_q      <= '0;
            strb_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            bunch_strb <= (state_d == StStrobe) && strb_hit;
            dac_cond   <= (state_d == StCond);
            if (accept) begin
                len_q    <= strb_len;
                gap_q    <= dac_delay;
                strb_cnt <= '0;
            end else if (bunch_strb && (strb_cnt != '1)) begin
                strb_cnt <= strb_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_bunch_strobe_gen.sv
// Directed bench for bunch_strobe_gen; per-shot activity is captured as cycle bitmasks.
module tb_bunch_strobe_gen;
    import bpm_timing_pkg::*;

    localparam int NONE = -5;

    logic clk = 1'b0;
    logic rst, trig;
    cnt_t strb_start, strb_len, dac_delay;
`ifdef STRB_DECIM_EN
    cnt_t strb_step;
`endif
    logic bunch_strb, dac_cond, busy;
    cnt_t strb_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bunch_strobe_gen dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .strb_start (strb_start),
        .strb_len   (strb_len),
        .dac_delay  (dac_delay),
`ifdef STRB_DECIM_EN
        .strb_step  (strb_step),
`endif
        .bunch_strb (bunch_strb),
        .dac_cond   (dac_cond),
        .busy       (busy),
        .strb_cnt   (strb_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of each mask is the output in cycle k+i, k being the accepting edge.
    task automatic run_shot(input string tag, input int s, input int l, input int d,
                            input int step, input int trig_drop, input int pulse_at,
                            input int len_at, input int rst_at,
                            input logic [63:0] e_strb, input logic [63:0] e_dac,
                            input logic [63:0] e_busy, input int e_cnt);
        logic [63:0] m_strb, m_dac, m_busy;
        m_strb = '0;
        m_dac  = '0;
        m_busy = '0;
        strb_start = cnt_t'(s);
        strb_len   = cnt_t'(l);
        dac_delay  = cnt_t'(d);
`ifdef STRB_DECIM_EN
        strb_step  = cnt_t'(step);
`endif
        trig = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            m_strb[i] = bunch_strb;
            m_dac[i]  = dac_cond;
            m_busy[i] = busy;
            if (i == trig_drop) trig = 1'b0;
            if (i == pulse_at) trig = 1'b1;
            if (i == pulse_at + 1) trig = 1'b0;
            if (i == len_at) strb_len = cnt_t'(9);
            if (i == rst_at) rst = 1'b1;
            if (i == rst_at + 3) rst = 1'b0;
            tick();
        end
        trig = 1'b0;
        rst  = 1'b0;
        check_eq({tag, "_strb"}, m_strb, e_strb);
        check_eq({tag, "_dac"}, m_dac, e_dac);
        check_eq({tag, "_overlap"}, m_strb & m_dac, 64'h0);
        check_eq({tag, "_busy"}, m_busy, e_busy);
        check_eq({tag, "_cnt"}, 64'(strb_cnt), 64'(e_cnt));
    endtask

    initial begin
        logic [2:0] acc;
        rst        = 1'b1;
        trig       = 1'b1;
        strb_start = cnt_t'(3);
        strb_len   = cnt_t'(4);
        dac_delay  = cnt_t'(2);
`ifdef STRB_DECIM_EN
        strb_step  = '0;
`endif
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acc |= {bunch_strb, dac_cond, busy};
        end
        check_eq("rst_outputs", 64'(acc), 64'h0);
        check_eq("rst_cnt", 64'(strb_cnt), 64'h0);
        rst  = 1'b0;
        trig = 1'b0;
        tick();
        tick();
        check_eq("idle_busy", 64'(busy), 64'h0);

        run_shot("basic", 3, 4, 2, 0, 1, NONE, NONE, NONE,
                 64'hF0, 64'h400, 64'h7FE, 4);
        run_shot("zero", 0, 0, 0, 0, 1, NONE, NONE, NONE,
                 64'h0, 64'h2, 64'h2, 0);
        run_shot("ignore", 3, 4, 2, 0, 1, 3, 2, NONE,
                 64'hF0, 64'h400, 64'h7FE, 4);
        run_shot("abort", 3, 4, 2, 0, 1, NONE, NONE, 5,
                 64'h30, 64'h0, 64'h3E, 0);
        run_shot("nodelay", 0, 3, 0, 0, 1, NONE, NONE, NONE,
                 64'hE, 64'h10, 64'h1E, 3);
        run_shot("nolen", 2, 0, 3, 0, 1, NONE, NONE, NONE,
                 64'h0, 64'h40, 64'h7E, 0);
        run_shot("held", 0, 1, 0, 0, 6, NONE, NONE, NONE,
                 64'h12, 64'h24, 64'h36, 1);
`ifdef STRB_DECIM_EN
        run_shot("decim", 1, 7, 2, 3, 1, NONE, NONE, NONE,
                 64'h124, 64'h800, 64'hFFE, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bunch_strobe_gen.md
Name: bunch_strobe_gen

Overview:
- Upstream timing stage for the BPM integrator.
- On each trigger, generates a contiguous `bunch_strb` window (the integrate-enable), then a single-cycle `dac_cond` pulse (the integrator clear / DAC-update condition).
- Delay, window length and gap are programmable; values are latched per trigger so mid-shot register writes cannot corrupt a window.
- `bunch_strb` and `dac_cond` are never high in the same cycle.

Parameters:
- CNT_W, 7, width of delay/length/gap counters and of the `strb_cnt` output.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- trig  in  1  shot trigger; level-sampled, accepted only in IDLE.
- strb_start  in  CNT_W  cycles from trigger acceptance to first strobe.
- strb_len  in  CNT_W  strobe window length in cycles.
- dac_delay  in  CNT_W  cycles between end of window and `dac_cond`.
- bunch_strb  out  1  integrate enable, registered.
- dac_cond  out  1  one-cycle clear/update pulse, registered.
- busy  out  1  high whenever state is not IDLE.
- strb_cnt  out  CNT_W  strobes issued this shot; holds until next accepted trigger.

Behaviour:
- Reset: state=IDLE; bunch_strb=0, dac_cond=0, busy=0, strb_cnt=0; latched settings=0. Reset mid-shot aborts immediately, with no trailing dac_cond.
- FSM states: IDLE, DELAY, STROBE, GAP, COND.
- Trigger acceptance: trig=1 in IDLE at edge k latches strb_start, strb_len and dac_delay, clears strb_cnt, and leaves IDLE.
- Timing: cycle k+1 is the first cycle out of IDLE.
  - bunch_strb is high for cycles k+1+S through k+S+L, where S=strb_start and L=strb_len.
  - dac_cond is high for exactly cycle k+1+S+L+D, where D=dac_delay.
  - The FSM returns to IDLE the cycle after dac_cond.
- Transitions:
  - IDLE→DELAY if S>0; else STROBE if L>0; else GAP if D>0; else COND.
  - DELAY counts S cycles, then goes to STROBE, or skips as above if L=0.
  - STROBE counts L cycles, then goes to GAP, or to COND if D=0.
  - GAP counts D cycles, then goes to COND.
  - COND lasts one cycle, then goes to IDLE.
- L=0: no strobe is issued; dac_cond still fires at k+1+S+D.
- strb_cnt increments on each cycle bunch_strb=1; it saturates at 2^CNT_W−1, which is unreachable with one window per shot.
- trig while busy is ignored (not queued). trig high in the COND cycle is ignored; trig held high re-fires at the first IDLE cycle.
- Input changes while busy have no effect on the current shot.
- Worst-case shot length: 1+3·(2^CNT_W−1)+1 cycles; no wrap.

Optional Feature:
- Macro: STRB_DECIM_EN.
- When defined:
  - Adds input strb_step (CNT_W bits), latched at trigger acceptance.
  - Within the STROBE window, bunch_strb is high only on window cycles 0, N, 2N, …, where N=max(strb_step,1).
  - Window duration is still L cycles; strb_cnt counts only asserted strobes.
- When undefined: no strb_step port; strobe is contiguous.

Decomposition:
- Shared package bpm_timing_pkg:
  - state enum {IDLE, DELAY, STROBE, GAP, COND};
  - CNT_W default constant;
  - cnt_t typedef.
- One natural sub-module: strb_down_counter (loadable down-counter with terminal-count flag), reused for DELAY, STROBE and GAP.

Test Plan:
- Reset with trig=1, S=3, L=4, D=2 → outputs stay 0 while rst=1.
- Release rst, then trig at edge k → bunch_strb high k+4..k+7, dac_cond only at k+10, strb_cnt=4, busy low from k+11.
- S=0, L=0, D=0 → dac_cond at k+1, bunch_strb never high, strb_cnt=0.
- Pulse trig again at k+3 during a shot, and change strb_len to 9 at k+2 → current shot timing unchanged; the second trig produces no shot.
- Assert rst at k+5 mid-STROBE → bunch_strb=0 from k+6 onward, no dac_cond, busy=0, strb_cnt=0.
- With STRB_DECIM_EN, S=1, L=7, strb_step=3 → bunch_strb at k+2, k+5, k+8; strb_cnt=3; dac_cond at k+9+D.
